// File: rtl/posit_pack_sched_pkg.sv
// Shared definitions for the posit packer scheduler: default widths, seed range, FSM states.
package posit_pkg;
  localparam int N_DEF    = 16;
  localparam int ES_DEF   = 3;
  localparam int SEED_MAX = N_DEF - 2;
  localparam int SEED_MIN = -(N_DEF - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;
endpackage

// File: rtl/posit_pack_sched_packer.sv
// Combinational posit packer: regime from signed seed, then ES exponent bits, then fraction,
// truncated to N-1 body bits behind a zero sign bit.
module posit_packer #(
  parameter int N  = 16,
  parameter int ES = 3
) (
  input  logic signed [N-1:0]  i_seed,
  input  logic        [ES-1:0] i_exp,
  input  logic        [N-1:0]  i_frac,
  output logic        [N-1:0]  o_posit
);
  localparam int WV = (N + 1) + 1 + ES + N;

  logic [WV-1:0] w_v;
  logic [WV-1:0] w_sh;
  int            w_shamt;

  // The regime run sits in a fixed N+1 bit prefix; shifting left exposes exactly the run length.
  always_comb begin
    if (!i_seed[N-1]) begin
      w_v     = {{(N+1){1'b1}}, 1'b0, i_exp, i_frac};
      w_shamt = N - int'(i_seed);
    end else begin
      w_v     = {{(N+1){1'b0}}, 1'b1, i_exp, i_frac};
      w_shamt = N + 1 + int'(i_seed);
    end
    w_sh    = w_v << w_shamt;
    o_posit = {1'b0, w_sh[WV-1 -: N-1]};
  end
endmodule

// File: rtl/posit_pack_sched.sv
// Round-robin sharing of one posit packer among NREQ requesters with a 2-entry tagged output FIFO
// and a RUN/DRAIN/HALT quiesce FSM. Optional seed clamping: define POSIT_SEED_SAT_EN.
module posit_pack_sched
  import posit_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int ES   = ES_DEF,
  parameter int NREQ = 4,
  parameter int TAGW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*N-1:0]    req_seed,
  input  logic [NREQ*ES-1:0]   req_exp,
  input  logic [NREQ*N-1:0]    req_frac,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_posit,
  output logic [TAGW-1:0]      out_tag,
  output logic                 out_sat,
  input  logic                 halt_req,
  output logic                 halted,
  output state_t               o_dbg_state
);
  // Handshake: a transfer happens on an edge where valid & ready are both high; ready may
  // depend on valid combinationally, valid never depends on ready.
  state_t          r_state, w_state_nxt;
  logic [1:0]      r_count;
  logic            r_rd, r_wr;
  logic [TAGW-1:0] r_rr;
  logic [N-1:0]    r_posit_q [2];
  logic [TAGW-1:0] r_tag_q   [2];
  logic            r_sat_q   [2];

  logic                 w_run, w_space, w_found, w_push, w_pop, w_sat;
  logic [TAGW-1:0]      w_sel, w_rr_nxt;
  int                   w_idx;
  logic signed [N-1:0]  w_seed_raw, w_seed;
  logic [ES-1:0]        w_exp;
  logic [N-1:0]         w_frac, w_posit;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (halt_req) w_state_nxt = DRAIN;
      DRAIN:   if (!halt_req) w_state_nxt = RUN;
               else if (r_count == 2'd0) w_state_nxt = HALT;
      HALT:    if (!halt_req) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    w_run       = (r_state == RUN);
    halted      = (r_state == HALT);
    o_dbg_state = r_state;
  end

  always_comb begin
    w_found = 1'b0;
    w_sel   = r_rr;
    w_idx   = 0;
    for (int j = 0; j < NREQ; j++) begin
      w_idx = (int'(r_rr) + j) % NREQ;
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_sel   = TAGW'(w_idx);
      end
    end
    w_rr_nxt = TAGW'((int'(w_sel) + 1) % NREQ);
  end

  assign out_valid = (r_count != 2'd0);
  assign w_pop     = out_valid & out_ready;
  assign w_space   = (r_count < 2'd2) | w_pop;

  always_comb begin
    req_ready = '0;
    if (rst_n && w_run && w_space && w_found) req_ready[w_sel] = 1'b1;
  end
  assign w_push = |req_ready;

  assign w_seed_raw = req_seed[int'(w_sel)*N +: N];
  assign w_exp      = req_exp[int'(w_sel)*ES +: ES];
  assign w_frac     = req_frac[int'(w_sel)*N +: N];

`ifdef POSIT_SEED_SAT_EN
  always_comb begin
    w_seed = w_seed_raw;
    w_sat  = 1'b0;
    if (int'(w_seed_raw) > SEED_MAX) begin
      w_seed = N'(SEED_MAX);
      w_sat  = 1'b1;
    end else if (int'(w_seed_raw) < SEED_MIN) begin
      w_seed = N'(SEED_MIN);
      w_sat  = 1'b1;
    end
  end
`else
  assign w_seed = w_seed_raw;
  assign w_sat  = 1'b0;
`endif

  posit_packer #(.N(N), .ES(ES)) u_packer (
    .i_seed  (w_seed),
    .i_exp   (w_exp),
    .i_frac  (w_frac),
    .o_posit (w_posit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_rr    <= '0;
      for (int k = 0; k < 2; k++) begin
        r_posit_q[k] <= '0;
        r_tag_q[k]   <= '0;
        r_sat_q[k]   <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_posit_q[r_wr] <= w_posit;
        r_tag_q[r_wr]   <= w_sel;
        r_sat_q[r_wr]   <= w_sat;
        r_wr            <= ~r_wr;
        r_rr            <= w_rr_nxt;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  assign out_posit = r_posit_q[r_rd];
  assign out_tag   = r_tag_q[r_rd];
  assign out_sat   = r_sat_q[r_rd];
endmodule

// File: tb/tb_posit_pack_sched.sv
// Directed bench for posit_pack_sched: packing vectors, round-robin, FIFO backpressure,
// halt/drain sequencing and mid-operation reset. Follows POSIT_SEED_SAT_EN if defined.
module tb_posit_pack_sched;
  import posit_pkg::*;
  localparam int N = 16, ES = 3, NREQ = 4, TAGW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*N-1:0] req_seed, req_frac;
  logic [NREQ*ES-1:0] req_exp;
  logic              out_valid, out_ready, out_sat, halt_req, halted;
  logic [N-1:0]      out_posit;
  logic [TAGW-1:0]   out_tag;
  state_t            dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] held_posit;

  posit_pack_sched #(.N(N), .ES(ES), .NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_seed(req_seed), .req_exp(req_exp), .req_frac(req_frac),
    .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit),
    .out_tag(out_tag), .out_sat(out_sat), .halt_req(halt_req), .halted(halted),
    .o_dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input int seed, input logic [2:0] e, input logic [15:0] f);
    req_seed[i*N +: N]  = 16'(seed);
    req_exp[i*ES +: ES] = e;
    req_frac[i*N +: N]  = f;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; out_ready = 1'b0; halt_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // independent bit-serial reference packer
  function automatic logic [15:0] pack_ref(input int k, input logic [2:0] e, input logic [15:0] f);
    logic bits[$];
    logic [15:0] r;
    if (k >= 0) begin
      for (int i = 0; i <= k; i++) bits.push_back(1'b1);
      bits.push_back(1'b0);
    end else begin
      for (int i = 0; i < -k; i++) bits.push_back(1'b0);
      bits.push_back(1'b1);
    end
    for (int i = 2; i >= 0; i--) bits.push_back(e[i]);
    for (int i = 15; i >= 0; i--) bits.push_back(f[i]);
    r = '0;
    for (int i = 0; i < 15; i++) r[14-i] = bits[i];
    return r;
  endfunction

  typedef struct {
    int          req;
    int          seed;
    logic [2:0]  e;
    logic [15:0] f;
    logic [15:0] posit;
    logic        sat;
  } vec_t;

  vec_t vecs[$];

  task automatic run_vec(input vec_t v);
    req_valid = '0;
    set_req(v.req, v.seed, v.e, v.f);
    req_valid[v.req] = 1'b1;
    out_ready = 1'b1;
    settle();
    chk("vec_ready", 32'(req_ready), 32'(4'b0001 << v.req));
    tick();
    req_valid = '0;
    chk("vec_valid", 32'(out_valid), 32'd1);
    chk("vec_posit", 32'(out_posit), 32'(v.posit));
    chk("vec_tag", 32'(out_tag), 32'(v.req));
    chk("vec_sat", 32'(out_sat), 32'(v.sat));
  endtask

  initial begin
    req_seed = '0; req_exp = '0; req_frac = '0;
    // reset state
    rst_n = 1'b0; req_valid = 4'hF; out_ready = 1'b0; halt_req = 1'b0;
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_posit", 32'(out_posit), 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_sat", 32'(out_sat), 32'd0);
    do_reset();

    // packing vectors, hand computed
    vecs.push_back('{0, 2, 3'b011, 16'hB500, 16'b0111001110110101, 1'b0});
    vecs.push_back('{1, 0, 3'b000, 16'h0000, 16'h4000, 1'b0});
    vecs.push_back('{2, -1, 3'b000, 16'h0000, 16'h2000, 1'b0});
    vecs.push_back('{3, 1, 3'b101, 16'h8000, 16'h6B00, 1'b0});
    vecs.push_back('{0, -3, 3'b010, 16'hC000, 16'h0AC0, 1'b0});
    vecs.push_back('{1, 5, 3'b111, 16'hFFFF, 16'h7EFF, 1'b0});
    vecs.push_back('{2, 14, 3'b111, 16'hFFFF, 16'h7FFF, 1'b0});
    vecs.push_back('{3, -15, 3'b111, 16'hFFFF, 16'h0000, 1'b0});
    foreach (vecs[i]) run_vec(vecs[i]);

    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v.req  = int'($urandom_range(0, 3));
      v.seed = int'($urandom_range(0, 29)) - 15;
      v.e    = 3'($urandom_range(0, 7));
      v.f    = 16'($urandom_range(0, 65535));
      v.posit = pack_ref(v.seed, v.e, v.f);
      v.sat  = 1'b0;
      run_vec(v);
    end

    // out-of-range seed: clamped with the macro, flagged only then
    req_valid = '0;
    set_req(0, 20, 3'b000, 16'h0000);
    req_valid[0] = 1'b1;
    tick();
    req_valid = '0;
    chk("sat_hi_valid", 32'(out_valid), 32'd1);
`ifdef POSIT_SEED_SAT_EN
    chk("sat_hi_posit", 32'(out_posit), 32'h7FFF);
    chk("sat_hi_flag", 32'(out_sat), 32'd1);
    set_req(1, -20, 3'b101, 16'hFFFF);
    req_valid[1] = 1'b1;
    tick();
    req_valid = '0;
    chk("sat_lo_posit", 32'(out_posit), 32'h0000);
    chk("sat_lo_flag", 32'(out_sat), 32'd1);
`else
    chk("sat_off_flag", 32'(out_sat), 32'd0);
`endif
    tick();
    chk("idle_empty", 32'(out_valid), 32'd0);

    // round robin, all valid, sustained
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, i, 3'(i), 16'(i * 16'h1111));
    req_valid = 4'hF; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      settle();
      chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (c % 4)));
      tick();
      chk("rr_tag", 32'(out_tag), 32'(c % 4));
      chk("rr_posit", 32'(out_posit), 32'(pack_ref(c % 4, 3'(c % 4), 16'((c % 4) * 16'h1111))));
    end

    // backpressure: third request held until the pop cycle, order preserved
    do_reset();
    out_ready = 1'b0; req_valid = 4'b0111;
    settle();
    chk("bp_ready0", 32'(req_ready), 32'b0001);
    exp_q.push_back(16'd0);
    tick();
    req_valid = 4'b0110;
    settle();
    chk("bp_ready1", 32'(req_ready), 32'b0010);
    exp_q.push_back(16'd1);
    tick();
    req_valid = 4'b0100;
    settle();
    chk("bp_full_ready", 32'(req_ready), 32'd0);
    held_posit = out_posit;
    tick();
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_tag", 32'(out_tag), 32'd0);
    chk("bp_hold_posit", 32'(out_posit), 32'(held_posit));
    chk("bp_still_full", 32'(req_ready), 32'd0);
    out_ready = 1'b1;
    settle();
    chk("bp_pop_ready", 32'(req_ready), 32'b0100);
    exp_q.push_back(16'd2);
    for (int c = 0; c < 3; c++) begin
      chk("bp_order", 32'(out_tag), 32'(exp_q.pop_front()));
      tick();
      req_valid = '0;
    end
    chk("bp_drained", 32'(out_valid), 32'd0);

    // halt with FIFO full, drain, halt, resume
    do_reset();
    out_ready = 1'b0; req_valid = 4'hF;
    tick();
    tick();
    halt_req = 1'b1;
    tick();
    chk("h_state_drain", 32'(dbg_state), 32'(DRAIN));
    chk("h_ready_drain", 32'(req_ready), 32'd0);
    out_ready = 1'b1;
    settle();
    chk("h_no_grant_pop", 32'(req_ready), 32'd0);
    tick();
    chk("h_count1", 32'(out_valid), 32'd1);
    tick();
    chk("h_empty", 32'(out_valid), 32'd0);
    chk("h_not_yet", 32'(halted), 32'd0);
    tick();
    chk("h_halted", 32'(halted), 32'd1);
    chk("h_ready_halt", 32'(req_ready), 32'd0);
    halt_req = 1'b0;
    settle();
    chk("h_still_halted", 32'(halted), 32'd1);
    tick();
    chk("h_resume", 32'(halted), 32'd0);
    chk("h_resume_ready", 32'(req_ready), 32'b0100);
    tick();
    chk("h_resume_tag", 32'(out_tag), 32'd2);

    // DRAIN back to RUN before empty
    do_reset();
    out_ready = 1'b0; req_valid = 4'hF;
    tick();
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    chk("d2r_state", 32'(dbg_state), 32'(RUN));
    chk("d2r_kept", 32'(out_valid), 32'd1);

    // reset with FIFO full
    do_reset();
    out_ready = 1'b0; req_valid = 4'b0011;
    tick();
    tick();
    chk("mr_full_ready", 32'(req_ready), 32'd0);
    req_valid = 4'hF; rst_n = 1'b0;
    tick();
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    settle();
    chk("mr_rr_restart", 32'(req_ready), 32'b0001);
    tick();
    chk("mr_tag", 32'(out_tag), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
